varint_ser_stream: RTL and testbench
====================================

VARINT_SER_STREAM -- requirements
Module: varint_ser_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 64, width of the unsigned field value (legal 8..64).
REQ-002 SHALL have derived localparam MAX_BYTES = ceil(DATA_W/7), giving 10 when DATA_W=64.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts a value.
REQ-007 SHALL have port in_data, input, DATA_W bits: field value to encode.
REQ-008 SHALL have port in_zigzag, input, 1 bit: treat in_data as signed and ZigZag-map it; sampled with in_data.
REQ-009 SHALL have port out_valid, output, 1 bit: out_byte is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts out_byte.
REQ-011 SHALL have port out_byte, output, 8 bits: varint byte; bit 7 is continuation, bits 6:0 are payload.
REQ-012 SHALL have port out_last, output, 1 bit: final byte of the current varint.
REQ-013 SHALL have port out_len, output, 4 bits: total byte count of the current varint, held stable for the whole varint.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and EMIT.
- In IDLE: in_ready=1, out_valid=0.
- In EMIT: in_ready=0, out_valid=1.
REQ-015 SHALL capture on in_valid&&in_ready:
- the mapped value goes into a DATA_W shift register;
- out_len = max(1, ceil((msb_index+1)/7));
- byte counter cleared;
- FSM moves to EMIT the next cycle.
REQ-016 SHALL drive out_byte[6:0] = shreg[6:0] and out_byte[7] = !out_last; out_last=1 iff byte counter == out_len-1.
REQ-017 SHALL, on out_valid&&out_ready with out_last=0, shift shreg right by 7 (zero fill) and increment the counter.
REQ-018 SHALL, on out_valid&&out_ready with out_last=1, return to IDLE; back-to-back values therefore have one IDLE cycle between them.
REQ-019 SHALL hold out_byte, out_last and out_len stable while out_valid=1 and out_ready=0.
REQ-020 SHALL encode value 0 as one byte 0x00 with out_last=1 and out_len=1.
REQ-021 SHALL produce for the maximum value (all ones) exactly MAX_BYTES bytes; the last byte carries the remaining DATA_W-7*(MAX_BYTES-1) bits.
REQ-022 SHALL ignore in_valid while in EMIT; the input is not consumed and in_data may change freely.
REQ-023 SHALL have latency of 1 cycle from input handshake to first out_valid, then one byte per cycle while out_ready=1.

Reset
REQ-024 SHALL, while rst_n=0, force:
- FSM to IDLE;
- shreg, byte counter and out_len to 0;
- out_valid=0 and in_ready=0.
REQ-025 SHALL assert in_ready=1 on the first clk edge after rst_n deasserts.
REQ-026 SHALL, on reset mid-varint, discard the remaining bytes; no partial varint resumes after reset.

Configuration
REQ-027 SHALL, with macro VARINT_ZIGZAG_EN defined and in_zigzag=1, map the captured value to (in_data<<1) XOR {DATA_W{in_data[DATA_W-1]}} before length computation.
REQ-028 SHALL, without VARINT_ZIGZAG_EN, keep the in_zigzag port but ignore it, encoding in_data unsigned; no ZigZag logic is synthesised.

Verification
REQ-029 SHALL cover: DATA_W=64, in_data=0 -> single byte 0x00, out_last=1, out_len=1.
REQ-030 SHALL cover: in_data=300 -> bytes 0xAC, 0x02; out_len=2; last asserted on 0x02.
REQ-031 SHALL cover: DATA_W=64, in_data=64'hFFFF_FFFF_FFFF_FFFF -> nine 0xFF then 0x01; out_len=10.
REQ-032 SHALL cover: VARINT_ZIGZAG_EN defined, in_zigzag=1, in_data=-1 -> 0x01; in_data=-2 -> 0x03; with the macro undefined, -1 -> ten-byte encoding.
REQ-033 SHALL cover: in_data=300, out_ready low for 3 cycles on the first byte -> 0xAC held stable, then 0xAC, 0x02 delivered, no byte lost or duplicated.
REQ-034 SHALL cover: reset asserted after the 2nd byte of a 10-byte varint -> out_valid=0 immediately; after release, in_data=1 -> single byte 0x01.

Source files
------------

// File: rtl/varint_ser_stream.sv
// Streaming varint (LEB128-style) serializer: one DATA_W value in, 1..MAX_BYTES bytes out.
// Optional ZigZag mapping of signed inputs is built only when VARINT_ZIGZAG_EN is defined.
module varint_ser_stream #(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_zigzag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_byte,
   output logic              out_last,
   output logic [3:0]        out_len
);

   localparam int MAX_BYTES = (DATA_W + 6) / 7;

   typedef enum logic {IDLE, EMIT} state_t;

   state_t            state;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] mapped;
   logic [3:0]        cnt;
   logic [3:0]        len_c;

   // Byte count = position of highest set bit grouped by 7; zero still needs one byte.
   function automatic logic [3:0] calc_len(input logic [DATA_W-1:0] v);
      logic [3:0] n;
      n = 4'd1;
      for (int i = 0; i < DATA_W; i++)
         if (v[i]) n = 4'(i / 7 + 1);
      return n;
   endfunction

`ifdef VARINT_ZIGZAG_EN
   always_comb begin
      mapped = in_data;
      if (in_zigzag)
         mapped = {in_data[DATA_W-2:0], 1'b0} ^ {DATA_W{in_data[DATA_W-1]}};
   end
`else
   logic unused_zigzag;
   assign unused_zigzag = in_zigzag;
   assign mapped        = in_data;
`endif

   assign len_c    = calc_len(mapped);
   assign out_last = (cnt == out_len - 4'd1);
   assign out_byte = {~out_last, shreg[6:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shreg     <= '0;
         cnt       <= '0;
         out_len   <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  shreg     <= mapped;
                  out_len   <= len_c;
                  cnt       <= '0;
                  state     <= EMIT;
                  in_ready  <= 1'b0;
                  out_valid <= 1'b1;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  if (out_last) begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                     in_ready  <= 1'b1;
                  end else begin
                     shreg <= shreg >> 7;
                     cnt   <= cnt + 4'd1;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b0;
            end
         endcase
      end
   end

   initial assert (MAX_BYTES <= 10 && DATA_W >= 8 && DATA_W <= 64)
      else $error("varint_ser_stream: DATA_W out of range");

endmodule

// File: tb/tb_varint_ser_stream.sv
// Randomized bench for varint_ser_stream against a divide-by-128 reference encoder.
module tb_varint_ser_stream;
   localparam int DATA_W = 64;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_zigzag = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [7:0]        out_byte;
   logic              out_last;
   logic [3:0]        out_len;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   varint_ser_stream #(.DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_zigzag(in_zigzag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_byte(out_byte), .out_last(out_last), .out_len(out_len)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: optional ZigZag via signed arithmetic, then base-128 digits LSB first.
   function automatic void ref_bytes(input logic [63:0] v, input logic zz, output byte unsigned q[$]);
      logic [63:0] u;
      longint s;
      u = v;
`ifdef VARINT_ZIGZAG_EN
      if (zz) begin
         s = longint'(v);
         u = (s >= 0) ? 64'(2 * s) : 64'(-2 * s - 1);
      end
`else
      s = 0;
      if (zz) s = 1;
`endif
      q = {};
      do begin
         q.push_back(8'(u % 128));
         u = u / 128;
      end while (u != 0);
      for (int i = 0; i < q.size() - 1; i++) q[i] = q[i] | 8'h80;
   endfunction

   // Push one value and drain its bytes; stall0 holds the first byte, abort_after>0 stops early.
   task automatic encode(input logic [63:0] v, input logic zz, input int stall0, input int abort_after);
      byte unsigned q[$];
      int to;
      int stall;
      ref_bytes(v, zz, q);
      @(negedge clk);
      to = 0;
      while (!in_ready && to < 20) begin @(negedge clk); to++; end
      if (to >= 20) begin chk("in_ready_timeout", 0, 1); return; end
      in_valid  = 1'b1;
      in_data   = v;
      in_zigzag = zz;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid  = 1'b0;
      in_data   = {$urandom, $urandom};
      chk("first_valid", out_valid, 1);
      chk("busy_in_ready", in_ready, 0);
      for (int i = 0; i < q.size(); i++) begin
         if (abort_after > 0 && i == abort_after) return;
         stall = (i == 0) ? stall0 : int'($urandom_range(0, 2));
         for (int k = 0; k < stall; k++) begin
            out_ready = 1'b0;
            in_valid  = $urandom_range(0, 1);
            in_data   = {$urandom, $urandom};
            chk("stall_byte", out_byte, q[i]);
            chk("stall_valid", out_valid, 1);
            @(negedge clk);
         end
         in_valid  = 1'b0;
         chk("byte", out_byte, q[i]);
         chk("last", out_last, (i == q.size() - 1));
         chk("len", out_len, q.size());
         chk("valid", out_valid, 1);
         out_ready = 1'b1;
         @(negedge clk);
      end
      out_ready = 1'b0;
      chk("idle_valid", out_valid, 0);
      chk("idle_ready", in_ready, 1);
   endtask

   initial begin
      logic [63:0] v;
      repeat (2) @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_len", out_len, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", in_ready, 1);

      encode(64'd0, 1'b0, 0, 0);
      encode(64'd300, 1'b0, 0, 0);
      encode(64'd300, 1'b0, 3, 0);
      encode('1, 1'b0, 0, 0);
      encode(64'd127, 1'b0, 0, 0);
      encode(64'd128, 1'b0, 1, 0);
      encode('1, 1'b1, 0, 0);        // -1 with zigzag request
      encode(-64'sd2, 1'b1, 0, 0);
      encode(64'd63, 1'b1, 0, 0);

      for (int n = 0; n < 40; n++) begin
         v = {$urandom, $urandom} >> $urandom_range(0, 63);
         encode(v, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 0);
      end

      // Reset after two bytes of a ten-byte varint.
      encode('1, 1'b0, 0, 2);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ready", in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_post_ready", in_ready, 1);
      chk("mid_rst_post_valid", out_valid, 0);
      encode(64'd1, 1'b0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
